updn_ramp_ctrl: RTL

Sequencer that drives the team's load/up/down counter through a programmed ramp profile. It loads a start value, counts up to a top limit, dwells, then counts down to a floor limit, optionally repeating. It sits between the control/register logic and the counter datapath: one Start pulse launches a full profile, and Busy/Done report progress.

---
 rtl/updn_pkg.sv | 22 ++
 rtl/updn_cnt_core.sv | 46 ++++
 rtl/updn_ramp_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/updn_pkg.sv
// rtl/updn_pkg.sv - shared constants and state encoding for the up/down ramp sequencer
//
// Purpose : default counter width, Phase width and the FSM state encoding
//           used by updn_ramp_ctrl and updn_cnt_core.
// Ports   : none (package)

package updn_pkg;

  localparam int UPDN_WIDTH_DEF = 5;
  localparam int PHASE_W        = 3;

  // Encodings are visible on Phase, so values are fixed; 6 and 7 are unused.
  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_UP    = 3'd2,
    ST_DWELL = 3'd3,
    ST_DOWN  = 3'd4,
    ST_DONE  = 3'd5
  } updn_state_e;

endpackage

// File: rtl/updn_cnt_core.sv
// rtl/updn_cnt_core.sv - saturating load/up/down counter with Low/High flags
//
// Purpose : WIDTH-bit counter; priority Load > Down > Up; saturates at 0 and
//           all-ones instead of wrapping.
// Ports   : CLK   clock
//           RST   asynchronous active-low reset (Q clears to 0)
//           Load  load D
//           Up    increment (ignored at all-ones)
//           Down  decrement (ignored at zero)
//           D     load value
//           Q     counter value
//           Low   Q is zero
//           High  Q is all-ones

module updn_cnt_core
  import updn_pkg::*;
#(
  parameter int WIDTH = UPDN_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Low,
  output logic             High
);

  assign Low  = (Q == '0);
  assign High = &Q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Q <= '0;
    end else if (Load) begin
      Q <= D;
    end else if (Down) begin
      if (!Low) Q <= Q - 1'b1;
    end else if (Up) begin
      if (!High) Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/updn_ramp_ctrl.sv
// rtl/updn_ramp_ctrl.sv - sequencer driving a load/up/down counter through a ramp profile
//
// Purpose : on Start, loads Start_Val, counts up to Top, holds Dwell+1 cycles,
//           counts down to Floor, then pulses Done. Optional repeat passes are
//           enabled by defining UPDN_RAMP_REPEAT_EN (adds Reps port).
// Ports   : CLK        clock
//           RST        asynchronous active-low reset
//           Start      launch pulse, honoured only in IDLE
//           Start_Val  counter load value
//           Top        upper turn-around value
//           Floor      lower end value
//           Dwell      extra hold cycles at Top
//           Reps       additional up/down passes (UPDN_RAMP_REPEAT_EN only)
//           Abort      synchronous abort back to IDLE, Count frozen
//           Count      counter value
//           Busy       high in LOAD/UP/DWELL/DOWN
//           Done       one-cycle completion pulse
//           Err        sticky configuration error (cleared by a valid Start)
//           Phase      current state encoding

module updn_ramp_ctrl
  import updn_pkg::*;
#(
  parameter int WIDTH   = UPDN_WIDTH_DEF,
  parameter int DWELL_W = 4
`ifdef UPDN_RAMP_REPEAT_EN
  ,
  parameter int REP_W   = 3
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Start_Val,
  input  logic [WIDTH-1:0]   Top,
  input  logic [WIDTH-1:0]   Floor,
  input  logic [DWELL_W-1:0] Dwell,
`ifdef UPDN_RAMP_REPEAT_EN
  input  logic [REP_W-1:0]   Reps,
`endif
  input  logic               Abort,
  output logic [WIDTH-1:0]   Count,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [PHASE_W-1:0] Phase
);

  updn_state_e        state_q, state_d;
  logic [WIDTH-1:0]   sv_q, top_q, floor_q;
  logic [DWELL_W-1:0] dwell_q, dcnt_q;
  logic               err_q;

  logic core_load, core_up, core_down;
  logic cnt_low, cnt_high;
  logic cap, accept, err_set;
  logic dwell_ld, dwell_dec, rep_dec, rep_more;
  logic cfg_ok, at_top, at_floor;

  assign cfg_ok   = (Floor <= Start_Val) && (Start_Val <= Top);
  assign at_top   = (Count == top_q);
  assign at_floor = (Count == floor_q);

`ifdef UPDN_RAMP_REPEAT_EN
  logic [REP_W-1:0] rcnt_q;
  assign rep_more = (rcnt_q != '0);
`else
  assign rep_more = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_up   = 1'b0;
    core_down = 1'b0;
    cap       = 1'b0;
    accept    = 1'b0;
    err_set   = 1'b0;
    dwell_ld  = 1'b0;
    dwell_dec = 1'b0;
    rep_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          cap = 1'b1;
          if (cfg_ok) begin
            accept  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        core_load = 1'b1;
        state_d   = ST_UP;
      end
      ST_UP: begin
        // Core saturation flags only back up the Top/Floor compares.
        if (!at_top) begin
          core_up = !cnt_high;
        end else begin
          dwell_ld = 1'b1;
          state_d  = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (dcnt_q != '0) dwell_dec = 1'b1;
        else              state_d   = ST_DOWN;
      end
      ST_DOWN: begin
        if (!at_floor) begin
          core_down = !cnt_low;
        end else if (rep_more) begin
          rep_dec = 1'b1;
          state_d = ST_UP;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything outside IDLE and freezes the counter.
    if (Abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      core_load = 1'b0;
      core_up   = 1'b0;
      core_down = 1'b0;
      dwell_ld  = 1'b0;
      dwell_dec = 1'b0;
      rep_dec   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      sv_q    <= '0;
      top_q   <= '0;
      floor_q <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        sv_q    <= Start_Val;
        top_q   <= Top;
        floor_q <= Floor;
        dwell_q <= Dwell;
      end
      if (err_set)     err_q <= 1'b1;
      else if (accept) err_q <= 1'b0;
      if (dwell_ld)       dcnt_q <= dwell_q;
      else if (dwell_dec) dcnt_q <= dcnt_q - 1'b1;
    end
  end

`ifdef UPDN_RAMP_REPEAT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         rcnt_q <= '0;
    else if (cap)     rcnt_q <= Reps;
    else if (rep_dec) rcnt_q <= rcnt_q - 1'b1;
  end
`endif

  updn_cnt_core #(.WIDTH(WIDTH)) u_core (
    .CLK  (CLK),
    .RST  (RST),
    .Load (core_load),
    .Up   (core_up),
    .Down (core_down),
    .D    (sv_q),
    .Q    (Count),
    .Low  (cnt_low),
    .High (cnt_high)
  );

  assign Busy  = (state_q == ST_LOAD) || (state_q == ST_UP) ||
                 (state_q == ST_DWELL) || (state_q == ST_DOWN);
  assign Done  = (state_q == ST_DONE);
  assign Err   = err_q;
  assign Phase = state_q;

endmodule
